// File: rtl/memory_op_unit.sv
// Executes pointer and RAM commands from the control FSM and drives a synchronous single-port RAM.
// Define MEM_AUTOINC_EN to post-increment the pointer after every READ/WRITE.
module memory_op_unit #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  // control::memory_op_e: 0 NOP, 1 READ, 2 WRITE, 3 ABSOLUTE, 4 REL_SUB, 5 REL_ADD
  input  logic [2:0]        op_i,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [ADDR_W-1:0] operand_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [2:0] OpNop    = 3'd0;
  localparam logic [2:0] OpRead   = 3'd1;
  localparam logic [2:0] OpWrite  = 3'd2;
  localparam logic [2:0] OpAbs    = 3'd3;
  localparam logic [2:0] OpRelSub = 3'd4;
  localparam logic [2:0] OpRelAdd = 3'd5;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StWr     = 2'd1;
  localparam logic [1:0] StRdReq  = 2'd2;
  localparam logic [1:0] StRdWait = 2'd3;

  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] RdWaitInit = CNT_W'(RD_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;
  logic [ADDR_W-1:0] rel_off;
  logic [ADDR_W-1:0] ptr_post_mem;

  assign op_ready_o = (state_q == StIdle);
  assign accept     = op_valid_i & op_ready_o;
  assign rel_off    = ADDR_W'(operand_i[DATA_W-1:0]);

  // Pointer value after a READ/WRITE completes; the RAM access itself always uses ptr_q.
`ifdef MEM_AUTOINC_EN
  assign ptr_post_mem = ptr_q + ADDR_W'(1);
`else
  assign ptr_post_mem = ptr_q;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (op_i)
            OpRead: begin
              state_d = StRdReq;
            end
            OpWrite: begin
              wdata_d = operand_i[DATA_W-1:0];
              state_d = StWr;
            end
            OpAbs: begin
              ptr_d  = operand_i;
              done_d = 1'b1;
            end
            OpRelAdd: begin
              ptr_d  = ptr_q + rel_off;
              done_d = 1'b1;
            end
            OpRelSub: begin
              ptr_d  = ptr_q - rel_off;
              done_d = 1'b1;
            end
            // NOP and unused encodings complete without side effects.
            default: begin
              done_d = 1'b1;
            end
          endcase
        end
      end

      StWr: begin
        state_d = StIdle;
        done_d  = 1'b1;
        ptr_d   = ptr_post_mem;
      end

      StRdReq: begin
        state_d = StRdWait;
        cnt_d   = RdWaitInit;
      end

      StRdWait: begin
        if (cnt_q == '0) begin
          rdata_d = mem_rdata_i;
          state_d = StIdle;
          done_d  = 1'b1;
          ptr_d   = ptr_post_mem;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rdata_o     = rdata_q;
  assign addr_o      = ptr_q;
  assign done_o      = done_q;
  assign mem_addr_o  = ptr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_we_o    = (state_q == StWr);
  assign mem_re_o    = (state_q == StRdReq);

`ifndef SYNTHESIS
  a_strobe_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(mem_we_o && mem_re_o));
  a_done_when_idle : assert property (@(posedge clk) disable iff (rst)
    done_o |-> op_ready_o);
`endif

endmodule

// File: tb/tb_memory_op_unit.sv
// Scoreboard bench for memory_op_unit: randomized commands against a behavioural pointer/RAM model.
// Honours MEM_AUTOINC_EN in the reference model.
module tb_memory_op_unit;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RD_LAT = 2;
  localparam int          ASIZE  = 1 << ADDR_W;

  localparam logic [2:0] OpNop    = 3'd0;
  localparam logic [2:0] OpRead   = 3'd1;
  localparam logic [2:0] OpWrite  = 3'd2;
  localparam logic [2:0] OpAbs    = 3'd3;
  localparam logic [2:0] OpRelSub = 3'd4;
  localparam logic [2:0] OpRelAdd = 3'd5;

`ifdef MEM_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        op;
  logic              op_valid;
  logic              op_ready;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] addr;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  memory_op_unit #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .op_i       (op),
    .op_valid_i (op_valid),
    .op_ready_o (op_ready),
    .operand_i  (operand),
    .rdata_o    (rdata),
    .addr_o     (addr),
    .done_o     (done),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_we_o   (mem_we),
    .mem_re_o   (mem_re),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM; off-cycle read data is random so a mistimed sample is visible.
  logic [DATA_W-1:0] ram     [ASIZE];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ASIZE; i++) ram[i] <= DATA_W'(i * 7 + 3);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    rd_pipe[0] <= mem_re ? ram[mem_addr] : DATA_W'($urandom);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  typedef struct {
    int done_cyc;
    int addr;
    int rdata;
  } exp_t;
  typedef struct {
    int addr;
    int data;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];

  int model_mem [ASIZE];
  int m_ptr;
  int m_rdata;
  int m_ready_cyc;
  int exp_re, exp_we;
  int re_cnt, we_cnt, overlap_cnt;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ASIZE; i++) model_mem[i] = (i * 7 + 3) % 256;
    m_ptr   = 0;
    m_rdata = 0;
  endtask

  // Reference behaviour of one accepted command at cycle t.
  task automatic model_op(input logic [2:0] o, input int opnd, input int t);
    exp_t e;
    wr_t  w;
    int   off;
    off = opnd % 256;
    e.done_cyc = t + 1;
    case (o)
      OpAbs:    m_ptr = opnd % ASIZE;
      OpRelAdd: m_ptr = (m_ptr + off) % ASIZE;
      OpRelSub: m_ptr = (m_ptr - off + ASIZE) % ASIZE;
      OpWrite: begin
        model_mem[m_ptr] = off;
        w.addr = m_ptr;
        w.data = off;
        wr_q.push_back(w);
        exp_we++;
        if (AutoInc) m_ptr = (m_ptr + 1) % ASIZE;
        e.done_cyc = t + 2;
      end
      OpRead: begin
        m_rdata = model_mem[m_ptr];
        exp_re++;
        if (AutoInc) m_ptr = (m_ptr + 1) % ASIZE;
        e.done_cyc = t + 2 + RD_LAT;
      end
      default: ;
    endcase
    e.addr  = m_ptr;
    e.rdata = m_rdata;
    exp_q.push_back(e);
    m_ready_cyc = e.done_cyc;
  endtask

  // Presents a command from the next falling edge and holds it until accepted.
  task automatic issue(input logic [2:0] o, input int opnd);
    int first;
    int waited;
    @(negedge clk);
    op       = o;
    operand  = ADDR_W'(opnd);
    op_valid = 1'b1;
    first    = cyc;
    waited   = 0;
    #1;
    while (!op_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!op_ready) begin
      check("accept_timeout", 64'(waited), 64'(0));
      op_valid = 1'b0;
    end else begin
      check("accept_cycle", 64'(cyc), 64'((first > m_ready_cyc) ? first : m_ready_cyc));
      model_op(o, opnd, cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      op_valid = 1'b0;
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports completion or strobes the RAM.
  initial begin
    exp_t e;
    wr_t  w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_we && mem_re) overlap_cnt++;
        if (mem_re) re_cnt++;
        if (mem_we) begin
          we_cnt++;
          if (wr_q.size() == 0) begin
            check("unexpected_write", 64'(1), 64'(0));
          end else begin
            w = wr_q.pop_front();
            check("write_addr", 64'(mem_addr), 64'(w.addr));
            check("write_data", 64'(mem_wdata), 64'(w.data));
          end
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("done_cycle", 64'(cyc), 64'(e.done_cyc));
            check("done_addr", 64'(addr), 64'(e.addr));
            check("done_rdata", 64'(rdata), 64'(e.rdata));
            check("done_ready", 64'(op_ready), 64'(1));
          end
        end
      end
    end
  end

  initial begin
    int o;
    int drain;
    rst = 1'b1;
    op = OpNop;
    operand = '0;
    op_valid = 1'b0;
    exp_re = 0; exp_we = 0;
    re_cnt = 0; we_cnt = 0; overlap_cnt = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    m_ready_cyc = cyc;
    check("rst_addr", 64'(addr), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_wdata", 64'(mem_wdata), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_strobes", 64'({mem_we, mem_re}), 64'(0));
    check("rst_ready", 64'(op_ready), 64'(1));

    // Pointer arithmetic and wrap in both directions.
    issue(OpAbs, 'h123);
    issue(OpAbs, 'h1FE);
    issue(OpRelAdd, 'h05);
    issue(OpRelSub, 'h04);
    issue(OpNop, 'h0AA);
    issue(3'd7, 'h155);
    idle(2);

    // Write then read back; the op queued behind the READ must wait for its done cycle.
    issue(OpAbs, 'h040);
    issue(OpWrite, 'hA5);
    issue(OpAbs, 'h040);
    issue(OpRead, 0);
    issue(OpRelAdd, 'h01);
    idle(3);

    // Two writes across the top of the address space.
    issue(OpAbs, 'h1FF);
    issue(OpWrite, 'h3C);
    issue(OpWrite, 'hC3);
    issue(OpRead, 0);
    idle(2);

    // Reset while the READ is waiting on the RAM.
    issue(OpRead, 0);
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    m_ready_cyc = cyc;
    #1;
    check("abort_done", 64'(done), 64'(0));
    check("abort_re", 64'(mem_re), 64'(0));
    check("abort_addr", 64'(addr), 64'(0));
    check("abort_ready", 64'(op_ready), 64'(1));
    check("abort_rdata", 64'(rdata), 64'(0));

    // Randomized command stream, including unused encodings and idle gaps.
    for (int n = 0; n < 300; n++) begin
      o = $urandom_range(0, 7);
      issue(3'(o), int'($urandom_range(0, ASIZE - 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);

    drain = 0;
    while ((exp_q.size() != 0) && drain < 100) begin
      @(negedge clk);
      drain++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'(0));
    check("writes_pending", 64'(wr_q.size()), 64'(0));
    check("strobe_overlap", 64'(overlap_cnt), 64'(0));
    check("read_strobes", 64'(re_cnt), 64'(exp_re));
    check("write_strobes", 64'(we_cnt), 64'(exp_we));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
